// File: rtl/mips_multicycle_controller.sv
// Purpose: Moore control FSM for the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Latency: outputs decode the state register combinationally; lw 5, sw/R/addi 4, beq 3, illegal 2 cycles.
// Backpressure: none; one state per clock. Optional addi support is built when MIPS_CTRL_ADDI_EN is defined.
module mips_multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               IorD,
    output logic               PCSrc,
    output logic               ALUSrcA,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTE  = STATE_W'(6),
        ALUWB    = STATE_W'(7),
`ifdef MIPS_CTRL_ADDI_EN
        BRANCH   = STATE_W'(8),
        ADDIEXEC = STATE_W'(9),
        ADDIWB   = STATE_W'(10)
`else
        BRANCH   = STATE_W'(8)
`endif
    } state_t;

    state_t state;
    state_t state_nxt;

    // Raw strobes before the reset gate.
    logic ir_write_raw;
    logic mem_write_raw;
    logic pc_write_raw;
    logic branch_raw;
    logic reg_write_raw;

    // State register: reset aborts any instruction straight back to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state control decode; unlisted controls stay at their defaults.
    always_comb begin
        state_nxt     = FETCH;
        MemToReg      = 1'b0;
        RegDst        = 1'b0;
        IorD          = 1'b0;
        PCSrc         = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        Illegal       = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        pc_write_raw  = 1'b0;
        branch_raw    = 1'b0;
        reg_write_raw = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcB      = 2'b01;
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                state_nxt    = DECODE;
            end
            DECODE: begin
                // ALU computes PC+1+SignImm so ALUOut holds the branch target.
                ALUSrcB = 2'b10;
                case (Opcode)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXECUTE;
                    OP_BEQ:       state_nxt = BRANCH;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_nxt = ADDIEXEC;
`endif
                    default: begin
                        Illegal   = 1'b1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                IorD      = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                MemToReg      = 1'b1;
                reg_write_raw = 1'b1;
                state_nxt     = FETCH;
            end
            MEMWRITE: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                state_nxt     = FETCH;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    6'b100000: ALUControl = ALU_ADD;
                    6'b100010: ALUControl = ALU_SUB;
                    6'b100100: ALUControl = ALU_AND;
                    6'b100101: ALUControl = ALU_OR;
                    6'b101010: ALUControl = ALU_SLT;
                    default:   ALUControl = ALU_ADD;
                endcase
                state_nxt = ALUWB;
            end
            ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
                state_nxt     = FETCH;
            end
            BRANCH: begin
                // PC loads ALUOut only when the datapath zero flag qualifies Branch.
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                branch_raw = 1'b1;
                PCSrc      = 1'b1;
                state_nxt  = FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ADDIEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_nxt  = ADDIWB;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
                state_nxt     = FETCH;
            end
`endif
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Write strobes are killed combinationally while reset is held so nothing commits before release.
    assign IRWrite  = ir_write_raw  & reset;
    assign MemWrite = mem_write_raw & reset;
    assign PCWrite  = pc_write_raw  & reset;
    assign Branch   = branch_raw    & reset;
    assign RegWrite = reg_write_raw & reset;

    assign State = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Purpose: self-checking bench for mips_multicycle_controller against an instruction-level model.
// Latency: checks every cycle of every instruction, sampled 1 time unit after the rising edge.
// Backpressure: none; directed reset/instruction steps followed by a randomized instruction stream.
module tb_mips_multicycle_controller;

`ifdef MIPS_CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       MemToReg, RegDst, IorD, PCSrc, ALUSrcA;
    logic       IRWrite, MemWrite, PCWrite, Branch, RegWrite;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_dst;
        logic       ior_d;
        logic       pc_src;
        logic       alu_src_a;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

    ctrl_t obs;
    int    exp_path[$];

    mips_multicycle_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .MemToReg   (MemToReg),
        .RegDst     (RegDst),
        .IorD       (IorD),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .RegWrite   (RegWrite),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .Illegal    (Illegal),
        .State      (State)
    );

    assign obs = {MemToReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite, MemWrite,
                  PCWrite, Branch, RegWrite, ALUSrcB, ALUControl, Illegal};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Instruction class helpers.
    function automatic bit is_illegal(input logic [5:0] op);
        return !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                 op == 6'b000100 || (op == 6'b001000 && ADDI_EN));
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Sequence of states an instruction visits, starting at FETCH.
    function automatic void plan(input logic [5:0] op);
        exp_path.delete();
        exp_path.push_back(0);
        exp_path.push_back(1);
        if (op == 6'b100011) begin
            exp_path.push_back(2); exp_path.push_back(3); exp_path.push_back(4);
        end else if (op == 6'b101011) begin
            exp_path.push_back(2); exp_path.push_back(5);
        end else if (op == 6'b000000) begin
            exp_path.push_back(6); exp_path.push_back(7);
        end else if (op == 6'b000100) begin
            exp_path.push_back(8);
        end else if (op == 6'b001000 && ADDI_EN) begin
            exp_path.push_back(9); exp_path.push_back(10);
        end
    endfunction

    // Control values required in each step of an instruction.
    function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        c.alu_ctrl = 3'b010;
        case (st)
            0: begin c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1; end
            1: begin c.alu_src_b = 2'b10; c.illegal = is_illegal(op); end
            2: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            3: begin c.ior_d = 1'b1; end
            4: begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            5: begin c.ior_d = 1'b1; c.mem_write = 1'b1; end
            6: begin c.alu_src_a = 1'b1; c.alu_ctrl = alu_of(fn); end
            7: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            8: begin c.alu_src_a = 1'b1; c.alu_ctrl = 3'b110; c.branch = 1'b1; c.pc_src = 1'b1; end
            9: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            10: begin c.reg_write = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t reset_ctrl();
        ctrl_t c;
        c = exp_ctrl(0, 6'd0, 6'd0);
        c.ir_write = 1'b0;
        c.pc_write = 1'b0;
        return c;
    endfunction

    task automatic check(input string tag, input int st, input ctrl_t e);
        checks++;
        assert (State === 4'(st)) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", tag, State, st);
        end
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s ctrl: got %h expected %h (state %0d)", tag, obs, e, st);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from its FETCH cycle until the next FETCH.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn);
        Opcode = op;
        Funct  = fn;
        plan(op);
        foreach (exp_path[i]) begin
            check(tag, exp_path[i], exp_ctrl(exp_path[i], op, fn));
            step();
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        case ($urandom_range(0, 5))
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000000;
            3: op = 6'b000100;
            4: op = 6'b001000;
            default: begin
                op = 6'($urandom_range(0, 63));
                while (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                       op == 6'b000100 || op == 6'b001000)
                    op = 6'($urandom_range(0, 63));
            end
        endcase
        return op;
    endfunction

    function automatic logic [5:0] rand_fn();
        case ($urandom_range(0, 5))
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            4: return 6'b101010;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        // Reset held for three cycles: FETCH state, strobes suppressed.
        reset = 1'b0;
        #1;
        check("reset_async", 0, reset_ctrl());
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", 0, reset_ctrl());
        end
        reset = 1'b1;
        #1;
        check("reset_release", 0, exp_ctrl(0, 6'd0, 6'd0));

        // Directed instructions.
        run_instr("lw", 6'b100011, 6'b000000);
        run_instr("rtype_slt", 6'b000000, 6'b101010);
        run_instr("rtype_sub", 6'b000000, 6'b100010);
        run_instr("beq", 6'b000100, 6'b000000);
        run_instr("addi", 6'b001000, 6'b000000);
        run_instr("illegal", 6'b111111, 6'b000000);

        // sw aborted by reset during MEMADR.
        Opcode = 6'b101011;
        Funct  = 6'b000000;
        check("sw_abort_fetch", 0, exp_ctrl(0, Opcode, Funct));
        step();
        check("sw_abort_decode", 1, exp_ctrl(1, Opcode, Funct));
        step();
        check("sw_abort_memadr", 2, exp_ctrl(2, Opcode, Funct));
        reset = 1'b0;
        #1;
        check("sw_abort_async", 0, reset_ctrl());
        step();
        check("sw_abort_hold", 0, reset_ctrl());
        reset = 1'b1;
        #1;
        check("sw_abort_release", 0, exp_ctrl(0, Opcode, Funct));
        run_instr("sw_after_abort", 6'b101011, 6'b000000);

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = rand_op();
            fn = rand_fn();
            run_instr("random", op, fn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
